// File: rtl/ex_result_stage.sv
// Execute result stage: registers the function-unit result into a 2-entry skid FIFO,
// maintains the committed NZCV status register and resolves conditional branches.
module ex_result_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_f,
    input  logic          in_v,
    input  logic          in_c,
    input  logic          in_n,
    input  logic          in_z,
    input  logic [RW-1:0] in_rd,
    input  logic          in_we,
    input  logic          in_setf,
    input  logic          in_br,
    input  logic [3:0]    in_cond,
    input  logic [DW-1:0] in_br_target,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_f,
    output logic [RW-1:0] out_rd,
    output logic          out_we,
    output logic [3:0]    status,
    output logic          br_taken,
    output logic [DW-1:0] br_target
);

    // Entry 0 is always the head; entry 1 only holds data when two entries are buffered.
    logic [1:0]    cnt_q,     cnt_d;
    logic [DW-1:0] e0_f_q,    e0_f_d;
    logic [RW-1:0] e0_rd_q,   e0_rd_d;
    logic          e0_we_q,   e0_we_d;
    logic [DW-1:0] e1_f_q,    e1_f_d;
    logic [RW-1:0] e1_rd_q,   e1_rd_d;
    logic          e1_we_q,   e1_we_d;
    logic [3:0]    status_q,  status_d;
    logic          br_q,      br_d;
    logic [DW-1:0] tgt_q,     tgt_d;

    logic accept;
    logic pop;
    logic fn, fz, fc, fv;
    logic cond_ok;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign accept    = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    assign out_f     = out_valid ? e0_f_q  : '0;
    assign out_rd    = out_valid ? e0_rd_q : '0;
    assign out_we    = out_valid & e0_we_q;
    assign status    = status_q;
    assign br_taken  = br_q;
    assign br_target = tgt_q;

    // Same-instruction flags win over the committed ones when the instruction sets flags.
    assign fn = in_setf ? in_n : status_q[3];
    assign fz = in_setf ? in_z : status_q[2];
    assign fc = in_setf ? in_c : status_q[1];
    assign fv = in_setf ? in_v : status_q[0];

    always_comb begin
        cond_ok = 1'b0;
        case (in_cond)
            4'b0000: cond_ok = 1'b1;
            4'b0001: cond_ok = fz;
            4'b0010: cond_ok = ~fz;
            4'b0011: cond_ok = fc;
            4'b0100: cond_ok = ~fc;
            4'b0101: cond_ok = fn;
            4'b0110: cond_ok = ~fn;
            4'b0111: cond_ok = fv;
            4'b1000: cond_ok = ~fv;
            4'b1001: cond_ok = (fn == fv);
            4'b1010: cond_ok = (fn != fv);
            4'b1011: cond_ok = ~fz & (fn == fv);
            4'b1100: cond_ok = fz | (fn != fv);
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        e0_f_d  = e0_f_q;
        e0_rd_d = e0_rd_q;
        e0_we_d = e0_we_q;
        e1_f_d  = e1_f_q;
        e1_rd_d = e1_rd_q;
        e1_we_d = e1_we_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            case ({accept, pop})
                2'b11: begin
                    // Only reachable with one entry held: the newcomer replaces the head.
                    e0_f_d  = in_f;
                    e0_rd_d = in_rd;
                    e0_we_d = in_we;
                end
                2'b01: begin
                    e0_f_d  = e1_f_q;
                    e0_rd_d = e1_rd_q;
                    e0_we_d = e1_we_q;
                    cnt_d   = cnt_q - 2'd1;
                end
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        e0_f_d  = in_f;
                        e0_rd_d = in_rd;
                        e0_we_d = in_we;
                    end else begin
                        e1_f_d  = in_f;
                        e1_rd_d = in_rd;
                        e1_we_d = in_we;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        status_d = status_q;
        if (accept && in_setf) begin
            status_d = {in_n, in_z, in_c, in_v};
        end
        br_d  = accept & in_br & cond_ok;
        tgt_d = br_d ? in_br_target : tgt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= 2'd0;
            e0_f_q   <= '0;
            e0_rd_q  <= '0;
            e0_we_q  <= 1'b0;
            e1_f_q   <= '0;
            e1_rd_q  <= '0;
            e1_we_q  <= 1'b0;
            status_q <= 4'b0000;
            br_q     <= 1'b0;
            tgt_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            e0_f_q   <= e0_f_d;
            e0_rd_q  <= e0_rd_d;
            e0_we_q  <= e0_we_d;
            e1_f_q   <= e1_f_d;
            e1_rd_q  <= e1_rd_d;
            e1_we_q  <= e1_we_d;
            status_q <= status_d;
            br_q     <= br_d;
            tgt_q    <= tgt_d;
        end
    end

endmodule

// File: tb/tb_ex_result_stage.sv
// Bench for ex_result_stage: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ex_result_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_f;
    logic        in_v, in_c, in_n, in_z;
    logic [4:0]  in_rd;
    logic        in_we, in_setf, in_br;
    logic [3:0]  in_cond;
    logic [31:0] in_br_target;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_f;
    logic [4:0]  out_rd;
    logic        out_we;
    logic [3:0]  status;
    logic        br_taken;
    logic [31:0] br_target;

    ex_result_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_f(in_f), .in_v(in_v), .in_c(in_c), .in_n(in_n), .in_z(in_z),
        .in_rd(in_rd), .in_we(in_we), .in_setf(in_setf), .in_br(in_br),
        .in_cond(in_cond), .in_br_target(in_br_target), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_f(out_f), .out_rd(out_rd), .out_we(out_we),
        .status(status), .br_taken(br_taken), .br_target(br_target)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: FIFO as a queue, flags as a 4-bit value.
    typedef struct packed {
        logic [31:0] f;
        logic [4:0]  rd;
        logic        we;
    } ent_t;

    ent_t        mq[$];
    logic [3:0]  m_status;
    logic        m_br;
    logic [31:0] m_tgt;

    function automatic bit cond_true(input logic [3:0] c, input logic [3:0] nzcv);
        bit n, z, cy, v;
        n = nzcv[3]; z = nzcv[2]; cy = nzcv[1]; v = nzcv[0];
        case (c)
            4'd0:  return 1'b1;
            4'd1:  return z;
            4'd2:  return !z;
            4'd3:  return cy;
            4'd4:  return !cy;
            4'd5:  return n;
            4'd6:  return !n;
            4'd7:  return v;
            4'd8:  return !v;
            4'd9:  return n == v;
            4'd10: return n != v;
            4'd11: return !z && (n == v);
            4'd12: return z || (n != v);
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_status = 4'b0;
            m_br     = 1'b0;
            m_tgt    = 32'b0;
        end else begin
            bit acc, pp, taken;
            logic [3:0] flags;
            ent_t e;
            acc = in_valid && (mq.size() < 2) && !flush;
            pp  = (mq.size() > 0) && out_ready;
            flags = in_setf ? {in_n, in_z, in_c, in_v} : m_status;
            taken = acc && in_br && cond_true(in_cond, flags);
            m_br = taken;
            if (taken) m_tgt = in_br_target;
            if (acc && in_setf) m_status = {in_n, in_z, in_c, in_v};
            if (flush) mq.delete();
            else begin
                if (pp) void'(mq.pop_front());
                if (acc) begin
                    e.f = in_f; e.rd = in_rd; e.we = in_we;
                    mq.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_in_ready",  {31'b0, in_ready},  {31'b0, mq.size() < 2});
            chk("m_out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
            chk("m_out_f",     out_f,              mq.size() > 0 ? mq[0].f : 32'b0);
            chk("m_out_rd",    {27'b0, out_rd},    mq.size() > 0 ? {27'b0, mq[0].rd} : 32'b0);
            chk("m_out_we",    {31'b0, out_we},    mq.size() > 0 ? {31'b0, mq[0].we} : 32'b0);
            chk("m_status",    {28'b0, status},    {28'b0, m_status});
            chk("m_br_taken",  {31'b0, br_taken},  {31'b0, m_br});
            chk("m_br_target", br_target,          m_tgt);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        in_valid = 0; in_f = 0; in_v = 0; in_c = 0; in_n = 0; in_z = 0;
        in_rd = 0; in_we = 0; in_setf = 0; in_br = 0; in_cond = 0;
        in_br_target = 0; flush = 0;
    endtask

    task automatic offer(input logic [31:0] f, input logic [4:0] rd, input logic we);
        in_valid = 1; in_f = f; in_rd = rd; in_we = we;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        out_ready = 0;
        #12;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_out_f",     out_f,              32'd0);
        chk("rst_status",    {28'b0, status},    32'd0);
        chk("rst_br_taken",  {31'b0, br_taken},  32'd0);
        chk("rst_br_target", br_target,          32'd0);
        rst = 0;

        // single pass
        out_ready = 1;
        offer(32'h1234, 5'd3, 1'b1);
        tick();
        chk("pass_out_valid", {31'b0, out_valid}, 32'd1);
        chk("pass_out_f",     out_f,              32'h1234);
        chk("pass_out_rd",    {27'b0, out_rd},    32'd3);
        in_valid = 0;
        tick();
        chk("pass_empty", {31'b0, out_valid}, 32'd0);

        // backpressure / full
        out_ready = 0;
        offer(32'd1, 5'd1, 1'b1); tick();
        offer(32'd2, 5'd2, 1'b0); tick();
        chk("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
        chk("bp_head1",         out_f,             32'd1);
        offer(32'd3, 5'd3, 1'b1); tick();
        chk("bp_head_stable",   out_f,             32'd1);
        out_ready = 1;
        tick();
        chk("bp_head2",         out_f,             32'd2);
        chk("bp_in_ready_free", {31'b0, in_ready}, 32'd1);
        tick();
        chk("bp_head3",         out_f,             32'd3);
        in_valid = 0;
        tick();
        chk("bp_drained", {31'b0, out_valid}, 32'd0);

        // flag bypass branch
        idle_inputs();
        in_valid = 1; in_setf = 1; in_z = 1; in_br = 1; in_cond = 4'b0001; in_br_target = 32'h40;
        tick();
        chk("byp_taken",  {31'b0, br_taken}, 32'd1);
        chk("byp_target", br_target,         32'h40);
        chk("byp_status", {28'b0, status},   32'b0100);
        idle_inputs();
        tick();
        chk("byp_pulse_end",   {31'b0, br_taken}, 32'd0);
        chk("byp_target_hold", br_target,         32'h40);

        // committed-flag branch: set status N=1,V=0, then LT (taken) and GE (not taken)
        in_valid = 1; in_setf = 1; in_n = 1;
        tick();
        idle_inputs();
        in_valid = 1; in_br = 1; in_cond = 4'b1010; in_br_target = 32'h80;
        tick();
        chk("lt_taken",  {31'b0, br_taken}, 32'd1);
        chk("lt_target", br_target,         32'h80);
        chk("lt_status", {28'b0, status},   32'b1000);
        in_cond = 4'b1001; in_br_target = 32'h99;
        tick();
        chk("ge_not_taken", {31'b0, br_taken}, 32'd0);
        chk("ge_target",    br_target,         32'h80);
        chk("ge_status",    {28'b0, status},   32'b1000);

        // flush with two entries held
        idle_inputs();
        out_ready = 0;
        tick(); tick();
        offer(32'hA, 5'd1, 1'b1); tick();
        offer(32'hB, 5'd2, 1'b1); tick();
        chk("fl_full", {31'b0, in_ready}, 32'd0);
        in_setf = 1; in_n = 1; in_z = 1; in_c = 1; in_v = 1; in_br = 1; in_cond = 0;
        in_br_target = 32'hDEAD; flush = 1;
        tick();
        chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_status",    {28'b0, status},    32'b1000);
        chk("fl_br_taken",  {31'b0, br_taken},  32'd0);
        idle_inputs();
        tick();

        // async reset with two entries held and a taken branch pending
        out_ready = 0;
        offer(32'h11, 5'd4, 1'b1); in_setf = 1; in_c = 1;
        tick();
        idle_inputs();
        offer(32'h22, 5'd5, 1'b1); in_br = 1; in_cond = 0; in_br_target = 32'h300;
        tick();
        idle_inputs();
        chk("ar_pre_taken", {31'b0, br_taken}, 32'd1);
        #2;
        rst = 1;
        #1;
        chk("ar_out_valid", {31'b0, out_valid}, 32'd0);
        chk("ar_status",    {28'b0, status},    32'd0);
        chk("ar_br_taken",  {31'b0, br_taken},  32'd0);
        chk("ar_in_ready",  {31'b0, in_ready},  32'd1);
        @(negedge clk);
        #1;
        rst = 0;

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            in_valid     = ($urandom_range(0, 9) < 7);
            in_f         = $urandom;
            in_rd        = 5'($urandom);
            in_we        = 1'($urandom);
            in_n         = 1'($urandom);
            in_z         = 1'($urandom);
            in_c         = 1'($urandom);
            in_v         = 1'($urandom);
            in_setf      = 1'($urandom);
            in_br        = 1'($urandom);
            in_cond      = 4'($urandom);
            in_br_target = $urandom;
            flush        = ($urandom_range(0, 31) == 0);
            out_ready    = ($urandom_range(0, 9) < 6);
            tick();
        end
        idle_inputs();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ex_result_stage.md
Name: ex_result_stage

Overview:
- Pipeline stage directly downstream of the execute function unit. It registers the unit's result (F) and flags (V, C, N, Z) together with destination and control fields.
- Holds a 2-entry skid buffer with a valid/ready handshake toward the memory/writeback stage.
- Maintains the architectural NZCV status register and resolves conditional branches from the flags.

Parameters:
- DW, 32, data width of result and branch target
- RW, 5, destination register index width

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  execute stage presents a valid result
- in_ready  out  1  stage can accept this cycle
- in_f  in  DW  function unit result F
- in_v, in_c, in_n, in_z  in  1 each  function unit flags
- in_rd  in  RW  destination register index
- in_we  in  1  register write enable
- in_setf  in  1  instruction updates the status register
- in_br  in  1  instruction is a conditional branch
- in_cond  in  4  branch condition code
- in_br_target  in  DW  branch target address
- flush  in  1  kill all buffered and incoming work
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts the head entry
- out_f  out  DW  head result
- out_rd  out  RW  head destination
- out_we  out  1  head write enable
- status  out  4  committed flags {N,Z,C,V}
- br_taken  out  1  one-cycle taken-branch pulse
- br_target  out  DW  target, valid while br_taken=1

Behaviour:
- Reset (asynchronous, active-high): both buffer entries invalid. out_valid=0, out_f=0, out_rd=0, out_we=0, status=0000, br_taken=0, br_target=0, in_ready=1. Asserting rst mid-operation discards all entries immediately.
- Accept: occurs when in_valid & in_ready & !flush.
- in_ready: is 1 when fewer than 2 entries are held. It is registered-derived from occupancy and never combinationally depends on out_ready.
- Buffer ordering: strict FIFO. Head = oldest entry. out_* always drive the head, and are 0 when empty.
- Pop: occurs when out_valid & out_ready.
- Simultaneous accept and pop:
  - Occupancy is unchanged.
  - With 1 entry held, the new entry becomes head on the next cycle.
  - With 2 entries held, in_ready=0, so no accept is possible.
- Latency: an accepted entry into an empty buffer appears on out_* the next cycle.
- Condition codes for in_cond:
  - 0000 always; 0001 EQ Z; 0010 NE !Z; 0011 CS C; 0100 CC !C; 0101 MI N; 0110 PL !N; 0111 VS V; 1000 VC !V.
  - 1001 GE N==V; 1010 LT N!=V; 1011 GT !Z&(N==V); 1100 LE Z|(N!=V).
  - 1101-1111 never.
- Flag source for the condition: the incoming in_n/in_z/in_c/in_v when in_setf=1 (same-instruction bypass); otherwise the committed status register.
- Branch resolution:
  - On accept with in_br=1 and condition true: br_taken=1 for exactly the next cycle, and br_target=in_br_target registered.
  - Otherwise br_taken=0 next cycle, and br_target holds its previous value.
  - A branch entry still enters the buffer with its in_we.
- Status update: on accept with in_setf=1, status <= {in_n,in_z,in_c,in_v} at that edge. Status is never affected by pops.
- Flush (synchronous): at the edge, both entries are invalidated and the same-cycle input is not accepted.
  - The flushed input updates neither status nor br_taken.
  - A br_taken already high from the previous cycle still completes its single-cycle pulse.
- Backpressure: head fields stay stable while out_valid=1 & out_ready=0.
- Flags from the function unit are consumed as-is; this stage does not recompute overflow or zero.

Test Plan:
- Reset then single pass:
  - Stimulus: rst pulse; accept in_f=0x0000_1234, in_rd=3, in_we=1, with out_ready=1.
  - Required: out_valid=1 next cycle, out_f=0x1234, out_rd=3, then empty.
- Backpressure/full:
  - Stimulus: out_ready=0; offer 3 consecutive entries (F=1,2,3).
  - Required: first two accepted, in_ready=0 on the third. Then with out_ready=1: outputs 1,2 in order, then entry 3 accepted and output.
- Flag bypass branch:
  - Stimulus: in_setf=1, in_z=1, in_br=1, in_cond=0001, in_br_target=0x40.
  - Required: br_taken=1 for one cycle, br_target=0x40, status=0100.
- Committed-flag branch:
  - Stimulus: status=1000 (N=1,V=0); accept in_br=1, in_setf=0, in_cond=1010 (LT).
  - Required: taken. Same with cond 1001 (GE): not taken, status unchanged.
- Flush:
  - Stimulus: two entries held; flush=1 together with in_valid=1, in_setf=1, in_br=1, cond=0000.
  - Required: out_valid=0 next cycle, status unchanged, br_taken=0.
- Async reset mid-stream:
  - Stimulus: assert rst between clock edges with 2 entries held.
  - Required: out_valid, status and br_taken drop to 0 immediately, without waiting for a clock edge.
